// File: rtl/mps_dmem_pkg.sv
// Shared constants for the MPS data-memory responder.
// Holds the MMIO map, STATUS bit positions and the default output FIFO depth.
`ifndef DMEM_ADDR_WIDTH
`define DMEM_ADDR_WIDTH 8
`endif
`ifndef DMEM_DATA_WIDTH
`define DMEM_DATA_WIDTH 8
`endif

package mps_dmem_pkg;

    localparam logic [7:0] MMIO_OUT    = 8'hFF;
    localparam logic [7:0] MMIO_STATUS = 8'hFE;
    localparam logic [7:0] MMIO_CYCLES = 8'hFD;

    localparam int ST_COUNT_LSB = 0;
    localparam int ST_FULL      = 3;
    localparam int ST_EMPTY     = 4;
    localparam int ST_OVF       = 5;

    localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/mps_out_fifo.sv
// Small synchronous FIFO feeding the MMIO OUT drain port.
// Head word reads as zero while empty.
module mps_out_fifo
    import mps_dmem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [2:0]       count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] buffer [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clock) begin
        if (push) buffer[wr_ptr] <= wdata;
    end

    assign full  = (count == 3'(DEPTH));
    assign empty = (count == 3'd0);
    assign rdata = empty ? '0 : buffer[rd_ptr];

endmodule

// File: rtl/mps_dmem_responder.sv
// MPS data-memory slave: RAM plus, with MPS_DMEM_MMIO_EN, an MMIO window
// (OUT FIFO at 0xFF, STATUS at 0xFE, CYCLES at 0xFD).
module mps_dmem_responder
    import mps_dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = `DMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = `DMEM_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic [ADDR_WIDTH-1:0] dmem_addr,
    input  logic                  dmem_wenable,
    input  logic [DATA_WIDTH-1:0] dmem_wvalue,
    output logic [DATA_WIDTH-1:0] dmem_rvalue,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic                  ram_we;

    always_ff @(posedge clock) begin
        if (ram_we) mem[dmem_addr] <= dmem_wvalue;
    end

`ifdef MPS_DMEM_MMIO_EN
    logic            is_out;
    logic            is_status;
    logic            is_cycles;
    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [2:0]      count;
    logic            overflow;
    logic [7:0]      cycles;
    logic [DATA_WIDTH-1:0] status;

    assign is_out    = (dmem_addr == ADDR_WIDTH'(MMIO_OUT));
    assign is_status = (dmem_addr == ADDR_WIDTH'(MMIO_STATUS));
    assign is_cycles = (dmem_addr == ADDR_WIDTH'(MMIO_CYCLES));

    assign ram_we    = dmem_wenable && nreset &&
                       !(is_out || is_status || is_cycles);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign push      = dmem_wenable && is_out && (!full || pop);
    assign out_valid = !empty;

    mps_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clock  (clock),
        .nreset (nreset),
        .push   (push),
        .pop    (pop),
        .wdata  (dmem_wvalue),
        .rdata  (out_data),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            overflow <= 1'b0;
            cycles   <= '0;
        end else begin
            cycles <= cycles + 8'd1;
            if (dmem_wenable && is_status)
                overflow <= 1'b0;
            else if (dmem_wenable && is_out && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_comb begin
        status                             = '0;
        status[ST_COUNT_LSB +: 3]          = count;
        status[ST_FULL]                    = full;
        status[ST_EMPTY]                   = empty;
        status[ST_OVF]                     = overflow;
    end

    always_comb begin
        dmem_rvalue = mem[dmem_addr];
        unique case (1'b1)
            is_out:    dmem_rvalue = '0;
            is_status: dmem_rvalue = status;
            is_cycles: dmem_rvalue = DATA_WIDTH'(cycles);
            default:   ;
        endcase
    end
`else
    logic unused_ready;

    assign unused_ready = out_ready;
    assign ram_we       = dmem_wenable && nreset;
    assign dmem_rvalue  = mem[dmem_addr];
    assign out_valid    = 1'b0;
    assign out_data     = '0;
`endif

endmodule

// File: tb/tb_mps_dmem_responder.sv
// Self-checking bench for mps_dmem_responder (both MPS_DMEM_MMIO_EN builds).
module tb_mps_dmem_responder;

    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic [7:0] dmem_addr = 8'h00;
    logic       dmem_wenable = 1'b0;
    logic [7:0] dmem_wvalue = 8'h00;
    logic       out_ready = 1'b0;
    logic [7:0] dmem_rvalue;
    logic [7:0] out_data;
    logic       out_valid;

    int n_pass = 0;
    int n_total = 0;

    mps_dmem_responder dut (
        .clock        (clock),
        .nreset       (nreset),
        .dmem_addr    (dmem_addr),
        .dmem_wenable (dmem_wenable),
        .dmem_wvalue  (dmem_wvalue),
        .dmem_rvalue  (dmem_rvalue),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clock = ~clock;

    // Behavioural model: memory image, FIFO as a queue, flag and counter.
    logic [7:0] m_mem [256];
    bit         m_known [256];
    logic [7:0] q [$];
    bit         m_ovf = 1'b0;
    logic [7:0] m_cyc = 8'h00;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s = 8'(q.size());
        if (q.size() == 4) s = s | 8'h08;
        if (q.size() == 0) s = s | 8'h10;
        if (m_ovf)         s = s | 8'h20;
        return s;
    endfunction

    function automatic bit m_read(input logic [7:0] a, output logic [7:0] v);
        v = 8'h00;
`ifdef MPS_DMEM_MMIO_EN
        if (a == 8'hFF) return 1'b1;
        if (a == 8'hFE) begin v = m_status(); return 1'b1; end
        if (a == 8'hFD) begin v = m_cyc; return 1'b1; end
`endif
        v = m_mem[a];
        return m_known[a];
    endfunction

    always @(negedge nreset) begin
        q.delete();
        m_ovf = 1'b0;
        m_cyc = 8'h00;
    end

    always @(posedge clock) begin
        if (nreset) begin
`ifdef MPS_DMEM_MMIO_EN
            bit pop_now;
            bit push_now;
            pop_now  = (q.size() > 0) && out_ready;
            push_now = 1'b0;
            if (dmem_wenable && dmem_addr == 8'hFF) begin
                if (q.size() < 4 || pop_now) push_now = 1'b1;
                else m_ovf = 1'b1;
            end
            if (dmem_wenable && dmem_addr == 8'hFE) m_ovf = 1'b0;
            if (pop_now) void'(q.pop_front());
            if (push_now) q.push_back(dmem_wvalue);
            m_cyc = m_cyc + 8'd1;
            if (dmem_wenable && dmem_addr < 8'hFD) begin
                m_mem[dmem_addr]   = dmem_wvalue;
                m_known[dmem_addr] = 1'b1;
            end
`else
            if (dmem_wenable) begin
                m_mem[dmem_addr]   = dmem_wvalue;
                m_known[dmem_addr] = 1'b1;
            end
`endif
        end
    end

    // Per-cycle comparison against the model, away from the clock edge.
    always @(negedge clock) begin
        logic [7:0] ev;
        #2;
        if (m_read(dmem_addr, ev)) chk("rvalue", dmem_rvalue, ev);
        chk("out_valid", {7'd0, out_valid}, {7'd0, q.size() > 0});
        if (q.size() > 0) chk("out_data", out_data, q[0]);
    end

    task automatic step(input logic [7:0] a, input logic we,
                        input logic [7:0] wv, input logic rdy);
        @(negedge clock);
        dmem_addr    = a;
        dmem_wenable = we;
        dmem_wvalue  = wv;
        out_ready    = rdy;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

        step(8'hFE, 1'b0, 8'h00, 1'b0);
        #2;
        chk("rst_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_data", out_data, 8'h00);
`ifdef MPS_DMEM_MMIO_EN
        chk("rst_status", dmem_rvalue, 8'h10);
`endif

        // Release and let the counter run.
        @(negedge clock);
        nreset    = 1'b1;
        dmem_addr = 8'hFD;
        repeat (300) @(posedge clock);
        @(negedge clock);
        #2;
`ifdef MPS_DMEM_MMIO_EN
        chk("cycles_300", dmem_rvalue, 8'd44);
`endif

        // RAM round trip.
        step(8'h10, 1'b1, 8'h00, 1'b0);
        step(8'h10, 1'b1, 8'h5A, 1'b0);
        #2 chk("ram_old", dmem_rvalue, 8'h00);
        step(8'h10, 1'b0, 8'h00, 1'b0);
        #2 chk("ram_new", dmem_rvalue, 8'h5A);
        step(8'h20, 1'b1, 8'hA5, 1'b0);
        step(8'h20, 1'b0, 8'h00, 1'b0);
        #2 chk("ram_20", dmem_rvalue, 8'hA5);

`ifdef MPS_DMEM_MMIO_EN
        // Push three with the consumer stalled, then drain in order.
        step(8'hFF, 1'b1, 8'h11, 1'b0);
        #2 chk("out_rd0", dmem_rvalue, 8'h00);
        step(8'hFF, 1'b1, 8'h22, 1'b0);
        step(8'hFF, 1'b1, 8'h33, 1'b0);
        step(8'hFE, 1'b0, 8'h00, 1'b0);
        #2;
        chk("stall_valid", {7'd0, out_valid}, 8'h01);
        chk("stall_head", out_data, 8'h11);
        chk("status_3", dmem_rvalue, 8'h03);
        step(8'hFE, 1'b0, 8'h00, 1'b1);
        #2 chk("drain_0", out_data, 8'h11);
        step(8'hFE, 1'b0, 8'h00, 1'b1);
        #2 chk("drain_1", out_data, 8'h22);
        step(8'hFE, 1'b0, 8'h00, 1'b1);
        #2 chk("drain_2", out_data, 8'h33);
        step(8'hFE, 1'b0, 8'h00, 1'b0);
        #2;
        chk("drained_valid", {7'd0, out_valid}, 8'h00);
        chk("drained_status", dmem_rvalue, 8'h10);

        // Overflow with five stalled pushes, then clear.
        for (int i = 1; i <= 5; i++) step(8'hFF, 1'b1, 8'(i), 1'b0);
        step(8'hFE, 1'b0, 8'h00, 1'b0);
        #2 chk("status_ovf", dmem_rvalue, 8'h2C);
        step(8'hFE, 1'b1, 8'h00, 1'b0);
        step(8'hFE, 1'b0, 8'h00, 1'b0);
        #2 chk("status_clr", dmem_rvalue, 8'h0C);

        // Full FIFO accepts a push when a pop happens in the same cycle.
        step(8'hFF, 1'b1, 8'h44, 1'b1);
        #2 chk("fp_head", out_data, 8'h01);
        step(8'hFE, 1'b0, 8'h00, 1'b0);
        #2 chk("fp_status", dmem_rvalue, 8'h0C);
        step(8'hFE, 1'b0, 8'h00, 1'b1);
        #2 chk("fp_d0", out_data, 8'h02);
        step(8'hFE, 1'b0, 8'h00, 1'b1);
        #2 chk("fp_d1", out_data, 8'h03);
        step(8'hFE, 1'b0, 8'h00, 1'b1);
        #2 chk("fp_d2", out_data, 8'h04);
        step(8'hFE, 1'b0, 8'h00, 1'b1);
        #2 chk("fp_last", out_data, 8'h44);
        step(8'hFE, 1'b0, 8'h00, 1'b0);
        #2 chk("fp_status_end", dmem_rvalue, 8'h10);

        // Reset asserted mid-drain, with a push in flight.
        step(8'hFF, 1'b1, 8'hAA, 1'b0);
        step(8'hFF, 1'b1, 8'hBB, 1'b0);
        step(8'hFF, 1'b1, 8'hCC, 1'b1);
        @(posedge clock);
        #1 nreset = 1'b0;
        dmem_addr    = 8'hFE;
        dmem_wenable = 1'b0;
        #1;
        chk("mid_rst_valid", {7'd0, out_valid}, 8'h00);
        chk("mid_rst_data", out_data, 8'h00);
        chk("mid_rst_status", dmem_rvalue, 8'h10);
        step(8'hFF, 1'b1, 8'hDD, 1'b0);
        #2 chk("rst_push_drop", {7'd0, out_valid}, 8'h00);
        @(negedge clock);
        nreset       = 1'b1;
        dmem_addr    = 8'hFD;
        dmem_wenable = 1'b0;
        step(8'hFD, 1'b0, 8'h00, 1'b0);
        #2 chk("cycles_1", dmem_rvalue, 8'h01);
        step(8'hFE, 1'b0, 8'h00, 1'b0);
        #2 chk("post_rst_status", dmem_rvalue, 8'h10);
`else
        // Without the MMIO window the top addresses are plain RAM.
        step(8'hFF, 1'b1, 8'h77, 1'b1);
        #2 chk("off_valid0", {7'd0, out_valid}, 8'h00);
        step(8'hFF, 1'b0, 8'h00, 1'b1);
        #2;
        chk("off_ff", dmem_rvalue, 8'h77);
        chk("off_valid1", {7'd0, out_valid}, 8'h00);
        chk("off_data", out_data, 8'h00);
        step(8'hFE, 1'b1, 8'h66, 1'b0);
        step(8'hFD, 1'b1, 8'h55, 1'b0);
        step(8'hFE, 1'b0, 8'h00, 1'b0);
        #2 chk("off_fe", dmem_rvalue, 8'h66);
        step(8'hFD, 1'b0, 8'h00, 1'b0);
        #2 chk("off_fd", dmem_rvalue, 8'h55);
`endif

        step(8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clock);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
